// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_arb_pkg : state type and default sizing for uart_tx_arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_arb_pkg;

  localparam int C_NREQ   = 4;
  localparam int C_DBIT   = 8;
  localparam int C_WD_MAX = 1023;
  localparam int C_WD_BIT = 10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter_if : requester / UART FIFO bundle of the arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NREQ = C_NREQ,
  parameter int DBIT = C_DBIT
);
  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] data;
  logic [NREQ-1:0]      last;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;

  // master: requesters plus the UART FIFO status; slave: the arbiter
  modport master (
    output req, data, last, tx_full,
    input  ack, grant, busy, wr_uart, w_data
  );

  modport slave (
    input  req, data, last, tx_full,
    output ack, grant, busy, wr_uart, w_data
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : first requesting index at or after ptr, wrapping at NREQ   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = C_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   index
);

  logic [IW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    pick    = '0;
    index   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = IW'((int'(ptr) + k) % NREQ);
      if (!w_found && req[w_pos]) begin
        w_found     = 1'b1;
        pick[w_pos] = 1'b1;
        index       = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin message arbiter in front of a UART TX  |
// | FIFO, with per-message watchdog.                         Rev 1.0     |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ   = C_NREQ,
  parameter int DBIT   = C_DBIT,
  parameter int WD_MAX = C_WD_MAX,
  parameter int WD_BIT = C_WD_BIT
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int                IW         = $clog2(NREQ);
  localparam logic [WD_BIT-1:0] C_WD_LIMIT = WD_BIT'(WD_MAX);

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [IW-1:0]     r_gidx;
  logic [IW-1:0]     r_rr_ptr;
  logic [WD_BIT-1:0] r_wd;

  logic [NREQ-1:0]   w_pick;
  logic [IW-1:0]     w_pick_idx;
  logic              w_send;
  logic              w_req_g;
  logic              w_last_g;
  logic              w_accept;
  logic              w_timeout;
  logic [WD_BIT-1:0] w_wd_inc;
  logic [IW-1:0]     w_ptr_next;
  logic [DBIT-1:0]   w_data_g;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (r_rr_ptr),
    .pick  (w_pick),
    .index (w_pick_idx)
  );

  assign w_send     = (r_state == SEND);
  assign w_req_g    = bus.req[r_gidx];
  assign w_last_g   = bus.last[r_gidx];
  assign w_data_g   = bus.data[int'(r_gidx)*DBIT +: DBIT];
  assign w_accept   = w_send & w_req_g & ~bus.tx_full;
  // Saturating increment; the limit is reached on the edge that ends the
  // WD_MAX-th silent cycle, so the owner gets exactly WD_MAX cycles.
  assign w_wd_inc   = (r_wd == C_WD_LIMIT) ? r_wd : r_wd + 1'b1;
  assign w_timeout  = w_send & ~w_req_g & (w_wd_inc == C_WD_LIMIT);
  assign w_ptr_next = IW'(next_idx(int'(r_gidx), NREQ));

  assign bus.grant   = r_grant;
  assign bus.busy    = w_send;
  assign bus.wr_uart = w_accept;
  assign bus.ack     = r_grant & {NREQ{w_accept}};
  assign bus.w_data  = w_accept ? w_data_g : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
      r_wd     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_state <= SEND;
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
            r_wd    <= '0;
          end
        end
        SEND: begin
          if (w_accept) begin
            r_wd <= '0;
            if (w_last_g) begin
              r_state  <= IDLE;
              r_grant  <= '0;
              r_rr_ptr <= w_ptr_next;
            end
          end else if (!w_req_g) begin
            r_wd <= w_wd_inc;
            if (w_timeout) begin
              r_state  <= IDLE;
              r_grant  <= '0;
              r_rr_ptr <= w_ptr_next;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter : directed + random bench with cycle-level model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int DBIT   = 8;
  localparam int WD_MAX = 15;
  localparam int WD_BIT = 4;
  localparam int QSZ    = 2048;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

  uart_tx_arbiter #(
    .NREQ   (NREQ),
    .DBIT   (DBIT),
    .WD_MAX (WD_MAX),
    .WD_BIT (WD_BIT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // per-requester byte queues: {last, byte}
  logic [DBIT:0] qb [NREQ][QSZ];
  int            head [NREQ];
  int            tail [NREQ];
  logic          hold [NREQ];

  // observations of the DUT, used by the directed literal checks
  int            wr_cyc[$];
  logic [7:0]    wr_dat[$];
  int            gnt_cyc[$];
  int            gnt_idx[$];
  int            fall_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic l);
    qb[i][tail[i]] = {l, b};
    tail[i]++;
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_dat.delete(); gnt_cyc.delete(); gnt_idx.delete(); fall_cyc.delete();
  endtask

  task automatic flush_all();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = tail[i];
      hold[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.tx_full = 1'b0;
    flush_all();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int c = 0;
    while (wr_dat.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk({name, "_wait"}, 32'(wr_dat.size() >= n), 32'd1);
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int c = 0;
    while (gnt_idx.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk({name, "_wait"}, 32'(gnt_idx.size() >= n), 32'd1);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++)
      if (head[i] != tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Requesters: present the queue head; an ack seen this cycle pops it at the edge.
  initial begin : client
    logic [NREQ-1:0]      acks, nreq, nlast;
    logic [NREQ*DBIT-1:0] ndata;
    bus.req  = '0;
    bus.data = '0;
    bus.last = '0;
    forever begin
      @(negedge clk);
      acks = bus.ack;
      @(posedge clk); #1;
      nreq = '0; nlast = '0; ndata = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (acks[i] === 1'b1 && head[i] != tail[i]) head[i]++;
        if (head[i] != tail[i] && !hold[i]) begin
          nreq[i]               = 1'b1;
          ndata[i*DBIT +: DBIT] = qb[i][head[i]][DBIT-1:0];
          nlast[i]              = qb[i][head[i]][DBIT];
        end
      end
      bus.req  = nreq;
      bus.data = ndata;
      bus.last = nlast;
    end
  end

  // Model: owner (-1 = nobody), round-robin start, count of silent owner cycles.
  initial begin : scoreboard
    int              m_owner, m_ptr, m_wd, nxt;
    logic [NREQ-1:0] e_grant, e_ack;
    logic [DBIT-1:0] e_wdata;
    logic            acc, prev_busy;
    m_owner = -1; m_ptr = 0; m_wd = 0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        m_owner = -1; m_ptr = 0; m_wd = 0;
      end
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      acc     = (m_owner >= 0) && (bus.req[m_owner] === 1'b1) && (bus.tx_full === 1'b0);
      e_ack   = acc ? e_grant : '0;
      e_wdata = acc ? bus.data[m_owner*DBIT +: DBIT] : '0;
      chk("grant",   32'(bus.grant),   32'(e_grant));
      chk("busy",    32'(bus.busy),    32'(m_owner >= 0));
      chk("ack",     32'(bus.ack),     32'(e_ack));
      chk("wr_uart", 32'(bus.wr_uart), 32'(acc));
      chk("w_data",  32'(bus.w_data),  32'(e_wdata));

      if (bus.wr_uart === 1'b1) begin
        wr_cyc.push_back(cyc);
        wr_dat.push_back(bus.w_data);
      end
      if (bus.busy === 1'b1 && !prev_busy) begin
        gnt_cyc.push_back(cyc);
        for (int i = 0; i < NREQ; i++)
          if (bus.grant[i] === 1'b1) gnt_idx.push_back(i);
      end
      if (bus.busy !== 1'b1 && prev_busy) fall_cyc.push_back(cyc);
      prev_busy = (bus.busy === 1'b1);

      if (rst_n === 1'b1) begin
        if (m_owner < 0) begin
          if (|bus.req) begin
            for (int k = 0; k < NREQ; k++) begin
              nxt = (m_ptr + k) % NREQ;
              if (m_owner < 0 && bus.req[nxt] === 1'b1) m_owner = nxt;
            end
            m_wd = 0;
          end
        end else if (acc) begin
          m_wd = 0;
          if (bus.last[m_owner] === 1'b1) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
          end
        end else if (bus.req[m_owner] !== 1'b1) begin
          if (m_wd < WD_MAX) m_wd++;
          if (m_wd == WD_MAX) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
          end
        end
      end
    end
  end

  initial begin : global_timeout
    #2_000_000;
    $display("FAIL global_timeout: time %0t exceeded the run limit", $time);
    $fatal(1, "run limit exceeded");
  end

  initial begin : stimulus
    int k;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0; tail[i] = 0; hold[i] = 1'b0;
    end
    rst_n       = 1'b0;
    bus.tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_grant", 32'(bus.grant),   32'h0);
    chk("rst_busy",  32'(bus.busy),    32'h0);
    chk("rst_wr",    32'(bus.wr_uart), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_ptr", 32'(dut.r_rr_ptr), 32'h0);

    // single three-byte message from requester 1
    clear_logs();
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
    wait_writes(3, 20, "single");
    repeat (2) @(posedge clk); #2;
    chk("single_gidx",  32'(gnt_idx[0]), 32'd1);
    chk("single_first", 32'(gnt_cyc[0]), 32'(wr_cyc[0]));
    chk("single_d0",    32'(wr_dat[0]),  32'h41);
    chk("single_d2",    32'(wr_dat[2]),  32'h43);
    chk("single_seq",   32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
    chk("single_end",   32'(fall_cyc[0] - wr_cyc[2]), 32'd1);
    chk("single_ptr",   32'(dut.r_rr_ptr), 32'd2);

    // contention: every requester with a one-byte message, requester 0 twice
    do_reset();
    for (int i = 0; i < NREQ; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    push(0, 8'hB0, 1'b1);
    wait_grants(5, 40, "cont");
    wait_writes(5, 40, "cont");
    for (int i = 0; i < 5; i++)
      chk($sformatf("cont_order%0d", i), 32'(gnt_idx[i]), 32'(i % NREQ));
    for (int i = 1; i < 5; i++)
      chk($sformatf("cont_gap%0d", i), 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd2);
    chk("cont_last_data", 32'(wr_dat[4]), 32'hB0);

    // backpressure: five full cycles after the first byte
    do_reset();
    for (int b = 0; b < 4; b++) push(2, 8'h10 + 8'(b), b == 3);
    wait_writes(1, 20, "bp_first");
    @(posedge clk); #2 bus.tx_full = 1'b1;
    repeat (5) @(posedge clk);
    #2 bus.tx_full = 1'b0;
    wait_writes(4, 30, "bp");
    chk("bp_stall", 32'(wr_cyc[1] - wr_cyc[0]), 32'd6);
    chk("bp_next",  32'(wr_cyc[2] - wr_cyc[1]), 32'd1);
    chk("bp_d1",    32'(wr_dat[1]), 32'h11);
    chk("bp_grants", 32'(gnt_idx.size()), 32'd1);

    // watchdog: requester 1 falls silent after its first byte
    do_reset();
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
    push(2, 8'h61, 1'b1);
    wait_writes(1, 20, "wd_first");
    hold[1] = 1'b1;
    k = wr_cyc[0];
    wait_grants(2, 60, "wd");
    wait_writes(2, 20, "wd_second");
    chk("wd_release", 32'(fall_cyc[0] - k), 32'd16);
    chk("wd_regrant", 32'(gnt_cyc[1] - k), 32'd17);
    chk("wd_gidx",    32'(gnt_idx[1]), 32'd2);
    chk("wd_data",    32'(wr_dat[1]), 32'h61);
    @(posedge clk); #2;
    head[1] = tail[1];
    hold[1] = 1'b0;

    // reset in the middle of a four-byte message
    do_reset();
    for (int b = 0; b < 4; b++) push(0, 8'hC0 + 8'(b), b == 3);
    wait_writes(2, 20, "mid");
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mid_grant", 32'(bus.grant),   32'h0);
    chk("mid_busy",  32'(bus.busy),    32'h0);
    chk("mid_wr",    32'(bus.wr_uart), 32'h0);
    chk("mid_wdata", 32'(bus.w_data),  32'h0);
    flush_all();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    repeat (2) @(posedge clk); #2;
    chk("mid_ptr", 32'(dut.r_rr_ptr), 32'h0);
    push(3, 8'hD3, 1'b1);
    wait_writes(1, 20, "mid_new");
    repeat (3) @(posedge clk); #2;
    chk("mid_gidx",   32'(gnt_idx[0]), 32'd3);
    chk("mid_nwr",    32'(wr_dat.size()), 32'd1);
    chk("mid_data",   32'(wr_dat[0]), 32'hD3);

    // wrap: pointer at 3, requesters 0 and 1 competing
    do_reset();
    push(2, 8'h70, 1'b1);
    wait_writes(1, 20, "wrap_pre");
    repeat (3) @(posedge clk); #2;
    chk("wrap_ptr", 32'(dut.r_rr_ptr), 32'd3);
    clear_logs();
    push(0, 8'h80, 1'b1); push(1, 8'h90, 1'b1);
    wait_writes(2, 20, "wrap");
    chk("wrap_gidx0", 32'(gnt_idx[0]), 32'd0);
    chk("wrap_data0", 32'(wr_dat[0]), 32'h80);
    chk("wrap_gidx1", 32'(gnt_idx[1]), 32'd1);

    // random traffic, backpressure and silent owners
    do_reset();
    repeat (800) begin
      @(posedge clk); #2;
      bus.tx_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (tail[i] - head[i] < 3 && $urandom_range(0, 3) == 0) begin
          k = $urandom_range(1, 4);
          for (int b = 0; b < k; b++) push(i, 8'($urandom), b == k - 1);
        end
        if ($urandom_range(0, 19) == 0) hold[i] = ~hold[i];
      end
    end
    @(posedge clk); #2;
    bus.tx_full = 1'b0;
    for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
    k = 0;
    while ((pending() || bus.busy === 1'b1) && k < 600) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rand_drained", 32'(pending()), 32'd0);
    chk("rand_progress", 32'(wr_dat.size() > 100), 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DBIT, default 8, data byte width.
REQ-003 SHALL have parameter WD_MAX, default 1023, watchdog limit in cycles; WD_BIT, default 10, its counter width.
REQ-004 Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low.
- req  input  NREQ  per-requester send request.
- data  input  NREQ*DBIT  per-requester byte; requester i occupies bits [i*DBIT +: DBIT].
- last  input  NREQ  marks the byte on data[i] as the final byte of the message.
- ack  output  NREQ  one-hot; byte of requester i accepted this cycle.
- grant  output  NREQ  one-hot owner of the UART, or zero.
- busy  output  1  a message is in progress.
- tx_full  input  1  UART transmit FIFO full.
- wr_uart  output  1  UART transmit FIFO write strobe.
- w_data  output  DBIT  byte to the UART transmit FIFO.

Function
REQ-005 SHALL implement FSM states IDLE and SEND; grant SHALL be zero in IDLE and one-hot in SEND.
REQ-006 IDLE: if any req is high, SHALL move to SEND next cycle, granting the first requesting index at or after rr_ptr, searching upward with wrap at NREQ.
REQ-007 SEND with granted index g: accept = req[g] and not tx_full; when accept, wr_uart, ack[g] = 1 combinationally in the same cycle and w_data = data[g].
REQ-008 wr_uart and ack SHALL be 0 whenever accept is 0; w_data SHALL be 0 when wr_uart is 0.
REQ-009 accept with last[g] = 1 SHALL return to IDLE next cycle, clear grant, and set rr_ptr = (g+1) mod NREQ.
REQ-010 The first byte SHALL be accepted no earlier than one cycle after req is first sampled high in IDLE.
REQ-011 Back-to-back: after a message ends, at least one IDLE cycle SHALL separate it from the next grant.
REQ-012 Grant SHALL not change mid-message for any req activity by other requesters.
REQ-013 tx_full high SHALL stall acceptance indefinitely without releasing grant and without resetting the watchdog.
REQ-014 Watchdog: a WD_BIT counter SHALL clear on every accept and on entry to SEND, and increment each SEND cycle where req[g] = 0.
REQ-015 When the watchdog reaches WD_MAX, SHALL return to IDLE next cycle and update rr_ptr as in REQ-009; no byte SHALL be written that cycle.
REQ-016 Watchdog SHALL saturate and never wrap.
REQ-017 busy SHALL equal (state == SEND).
REQ-018 Requests from non-granted requesters SHALL never be acked.

Reset
REQ-019 On reset low, SHALL immediately force state IDLE, rr_ptr 0, watchdog 0, grant 0, busy 0, ack 0, wr_uart 0, w_data 0.
REQ-020 Reset mid-message SHALL abandon the message; no byte SHALL be written while reset is low or in the first cycle after release.
REQ-021 Reset deassertion SHALL be consumed synchronously (registered state only leaves reset on a clk edge).

Structure
REQ-022 The shared package uart_arb_pkg SHALL hold the state enumeration (IDLE, SEND) and the default constants NREQ, DBIT and WD_MAX.
REQ-023 The round-robin search SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs one-hot pick and index).
REQ-024 The FSM, rr_ptr, watchdog and output muxing SHALL reside in uart_tx_arbiter.

Verification
REQ-025 Single message:
- Stimulus: req[1] with bytes 0x41, 0x42, 0x43 (last on 0x43), tx_full = 0.
- Response: grant = 0010 one cycle after req; w_data 0x41/0x42/0x43 on three consecutive cycles; IDLE after; rr_ptr = 2.
REQ-026 Contention:
- Stimulus: req = 1111 constantly, each requester sending 1-byte messages.
- Response: grants in order 0, 1, 2, 3, 0; each grant separated by one IDLE cycle.
REQ-027 Backpressure:
- Stimulus: tx_full high for 5 cycles mid-message.
- Response: wr_uart = 0 and grant held for those cycles; the next byte is written on the first cycle tx_full is low.
REQ-028 Watchdog:
- Stimulus: WD_MAX = 15; granted requester drops req without last.
- Response: IDLE after exactly 15 SEND cycles with req low; no ack; next requester granted.
REQ-029 Reset mid-message:
- Stimulus: reset low after byte 2 of 4.
- Response: all outputs 0 immediately; after release, a new req[3] is granted from rr_ptr 0; no stray wr_uart.
REQ-030 Wrap:
- Stimulus: rr_ptr = 3; req = 0011.
- Response: grant = 0001.
